// File: rtl/sprite_motion_ctrl_pkg.sv
// Shared definitions for the sprite motion controller and the address generator:
// map geometry, sprite-sheet frame counts and the update FSM state encoding.
package sprite_motion_ctrl_pkg;

    localparam int TILE_SHIFT        = 5;
    localparam int SPR_W             = 32;
    localparam int SPR_H             = 32;
    localparam int MAP_COLS          = 20;
    localparam int MAP_ROWS          = 15;
    localparam int SHEET_IDLE_FRAMES = 4;
    localparam int SHEET_WALK_FRAMES = 6;

    typedef enum logic [2:0] {
        ST_WAIT = 3'd0,
        ST_HQ0  = 3'd1,
        ST_HQ1  = 3'd2,
        ST_HRES = 3'd3,
        ST_VQ0  = 3'd4,
        ST_VQ1  = 3'd5,
        ST_VRES = 3'd6,
        ST_ANIM = 3'd7
    } motion_state_t;

    // Next animation frame, wrapping after the last frame of a sheet of 'count' frames.
    function automatic logic [2:0] frame_wrap(input logic [2:0] cur, input logic [2:0] count);
        logic [2:0] nxt;
        if (cur >= count - 3'd1) begin
            nxt = 3'd0;
        end else begin
            nxt = cur + 3'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sprite_motion_ctrl_tile_snap.sv
// One-axis collision helper: converts a candidate position into the grid cell of its
// leading edge, forces out-of-map probes solid and computes the snap-back position.
module tile_snap
    import sprite_motion_ctrl_pkg::*;
#(
    parameter int LEAD_LIMIT  = MAP_COLS,
    parameter int ORTHO_LIMIT = MAP_ROWS,
    parameter int SPAN        = SPR_W,
    parameter int ORTHO_SPAN  = SPR_H,
    parameter int LEAD_W      = 5,
    parameter int ORTHO_W     = 4
) (
    input  logic signed [10:0]  pos_n,
    input  logic                dir_pos,
    input  logic [9:0]          ortho,
    input  logic                ortho_far,
    output logic [LEAD_W-1:0]   lead_cell,
    output logic [ORTHO_W-1:0]  ortho_cell,
    output logic                force_solid,
    output logic [9:0]          snap_pos
);

    localparam logic signed [10:0] SPAN_S       = 11'(SPAN);
    localparam logic signed [10:0] EDGE_S       = 11'(SPAN - 1);
    localparam logic signed [10:0] LEAD_LIM_S   = 11'(LEAD_LIMIT);
    localparam logic [10:0]        ORTHO_EDGE_S = 11'(ORTHO_SPAN - 1);
    localparam logic [10:0]        ORTHO_LIM_S  = 11'(ORTHO_LIMIT);

    logic signed [10:0] lead_s;
    logic signed [10:0] cell_s;
    logic signed [10:0] snap_s;
    logic [10:0]        ortho_edge_s;
    logic [10:0]        ortho_full_s;

    // Leading-edge cell, probe cell on the other axis, bounds forcing and snap target.
    always_comb begin
        if (dir_pos) begin
            lead_s = pos_n + EDGE_S;
        end else begin
            lead_s = pos_n;
        end
        cell_s = lead_s >>> TILE_SHIFT;
        if (ortho_far) begin
            ortho_edge_s = {1'b0, ortho} + ORTHO_EDGE_S;
        end else begin
            ortho_edge_s = {1'b0, ortho};
        end
        ortho_full_s = ortho_edge_s >> TILE_SHIFT;
        force_solid  = (lead_s < 11'sd0) || (cell_s >= LEAD_LIM_S) || (ortho_full_s >= ORTHO_LIM_S);
        // Moving positive: park against the near side of the hit cell; otherwise just past it.
        if (dir_pos) begin
            snap_s = (cell_s <<< TILE_SHIFT) - SPAN_S;
        end else begin
            snap_s = (cell_s + 11'sd1) <<< TILE_SHIFT;
        end
        lead_cell  = LEAD_W'(cell_s);
        ortho_cell = ORTHO_W'(ortho_full_s);
        snap_pos   = 10'(snap_s);
    end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Per-frame player controller: walk, jump and gravity with tile collision through the
// shared lookup port; the visible sprite state is committed all at once in ANIM.
module sprite_motion_ctrl
    import sprite_motion_ctrl_pkg::*;
#(
    parameter int INIT_X      = 32,
    parameter int INIT_Y      = 416,
    parameter int WALK_SPD    = 2,
    parameter int JUMP_V      = 10,
    parameter int FALL_MAX    = 8,
    parameter int ANIM_DIV    = 6,
    parameter int IDLE_FRAMES = SHEET_IDLE_FRAMES,
    parameter int WALK_FRAMES = SHEET_WALK_FRAMES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    output logic [4:0] tile_qx,
    output logic [3:0] tile_qy,
    input  logic       tile_solid,
    output logic [9:0] img_x,
    output logic [9:0] img_y,
    output logic [2:0] frame_idx,
    output logic       is_moving,
    output logic       face_left,
    output logic       on_ground,
    output logic       busy
);

    localparam logic signed [10:0] WALK_S     = 11'(WALK_SPD);
    localparam logic signed [5:0]  JUMP_S     = 6'(-JUMP_V);
    localparam logic signed [5:0]  FALL_S     = 6'(FALL_MAX);
    localparam logic [2:0]         ANIM_DIV_S = 3'(ANIM_DIV);
    localparam logic [2:0]         IDLE_CNT_S = 3'(IDLE_FRAMES);
    localparam logic [2:0]         WALK_CNT_S = 3'(WALK_FRAMES);

    motion_state_t state_r, state_s;

    logic [9:0]         x_r, y_r;
    logic signed [5:0]  vel_r;
    logic               og_r;
    logic signed [10:0] dx_r;
    logic [2:0]         cnt_r;
    logic               hit0_r, force_r;

    logic signed [10:0] dx_btn_s, dx_s, nx_s, ny_s;
    logic signed [5:0]  vel_grav_s, vel_new_s, vel_s;
    logic               jump_s, hit1_s, h_block_s, v_block_s, moving_s, face_s;
    logic [9:0]         x_new_s, x_s;
    logic [4:0]         h_cell_s, v_ocell_s, qx_s;
    logic [3:0]         h_ocell_s, v_cell_s, qy_s;
    logic               h_force_s, v_force_s, q_force_s;
    logic [9:0]         h_snap_s, v_snap_s;
    logic [2:0]         frame_s, cnt_s;

    // Horizontal step from the buttons, candidate x and its collision resolution.
    always_comb begin
        if (btn_right && !btn_left) begin
            dx_btn_s = WALK_S;
        end else if (btn_left && !btn_right) begin
            dx_btn_s = -WALK_S;
        end else begin
            dx_btn_s = 11'sd0;
        end
        if (state_r == ST_WAIT) begin
            dx_s = dx_btn_s;
        end else begin
            dx_s = dx_r;
        end
        nx_s      = $signed({1'b0, x_r}) + dx_s;
        hit1_s    = tile_solid | force_r;
        h_block_s = (dx_r != 11'sd0) && (hit0_r || hit1_s);
        if (h_block_s) begin
            x_new_s = h_snap_s;
        end else begin
            x_new_s = 10'(nx_s);
        end
    end

    // Jump/gravity velocity; during HRES the vertical probes already use the resolved x.
    always_comb begin
        jump_s = og_r & btn_jump;
        if (vel_r >= FALL_S) begin
            vel_grav_s = FALL_S;
        end else begin
            vel_grav_s = vel_r + 6'sd1;
        end
        if (jump_s) begin
            vel_new_s = JUMP_S;
        end else begin
            vel_new_s = vel_grav_s;
        end
        if (state_r == ST_HRES) begin
            vel_s = vel_new_s;
            x_s   = x_new_s;
        end else begin
            vel_s = vel_r;
            x_s   = x_r;
        end
        ny_s      = $signed({1'b0, y_r}) + 11'(vel_s);
        v_block_s = hit0_r | hit1_s;
    end

    tile_snap #(
        .LEAD_LIMIT (MAP_COLS),
        .ORTHO_LIMIT(MAP_ROWS),
        .SPAN       (SPR_W),
        .ORTHO_SPAN (SPR_H),
        .LEAD_W     (5),
        .ORTHO_W    (4)
    ) u_snap_h (
        .pos_n      (nx_s),
        .dir_pos    (dx_s > 11'sd0),
        .ortho      (y_r),
        .ortho_far  (state_r == ST_HQ0),
        .lead_cell  (h_cell_s),
        .ortho_cell (h_ocell_s),
        .force_solid(h_force_s),
        .snap_pos   (h_snap_s)
    );

    tile_snap #(
        .LEAD_LIMIT (MAP_ROWS),
        .ORTHO_LIMIT(MAP_COLS),
        .SPAN       (SPR_H),
        .ORTHO_SPAN (SPR_W),
        .LEAD_W     (4),
        .ORTHO_W    (5)
    ) u_snap_v (
        .pos_n      (ny_s),
        .dir_pos    (vel_s > 6'sd0),
        .ortho      (x_s),
        .ortho_far  (state_r == ST_VQ0),
        .lead_cell  (v_cell_s),
        .ortho_cell (v_ocell_s),
        .force_solid(v_force_s),
        .snap_pos   (v_snap_s)
    );

    // Next-state sequencing; a tick outside WAIT is simply dropped.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_WAIT: begin
                if (frame_tick) begin
                    state_s = ST_HQ0;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_HQ0:  state_s = ST_HQ1;
            ST_HQ1:  state_s = ST_HRES;
            ST_HRES: state_s = ST_VQ0;
            ST_VQ0:  state_s = ST_VQ1;
            ST_VQ1:  state_s = ST_VRES;
            ST_VRES: state_s = ST_ANIM;
            ST_ANIM: state_s = ST_WAIT;
            default: state_s = ST_WAIT;
        endcase
    end

    // Query presented for the upcoming probe state, so its answer lands one state later.
    always_comb begin
        qx_s      = tile_qx;
        qy_s      = tile_qy;
        q_force_s = force_r;
        case (state_r)
            ST_WAIT: begin
                if (frame_tick) begin
                    qx_s      = h_cell_s;
                    qy_s      = h_ocell_s;
                    q_force_s = h_force_s;
                end else begin
                    q_force_s = force_r;
                end
            end
            ST_HQ0: begin
                qx_s      = h_cell_s;
                qy_s      = h_ocell_s;
                q_force_s = h_force_s;
            end
            ST_HRES, ST_VQ0: begin
                qx_s      = v_ocell_s;
                qy_s      = v_cell_s;
                q_force_s = v_force_s;
            end
            default: q_force_s = force_r;
        endcase
    end

    // Animation step and facing computed for the commit in ANIM.
    always_comb begin
        moving_s = (dx_r != 11'sd0);
        if (dx_r < 11'sd0) begin
            face_s = 1'b1;
        end else if (dx_r > 11'sd0) begin
            face_s = 1'b0;
        end else begin
            face_s = face_left;
        end
        if (moving_s != is_moving) begin
            frame_s = 3'd0;
            cnt_s   = 3'd0;
        end else if (cnt_r + 3'd1 == ANIM_DIV_S) begin
            cnt_s   = 3'd0;
            frame_s = frame_wrap(frame_idx, moving_s ? WALK_CNT_S : IDLE_CNT_S);
        end else begin
            cnt_s   = cnt_r + 3'd1;
            frame_s = frame_idx;
        end
    end

    // State, query port and busy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_WAIT;
            tile_qx <= 5'd0;
            tile_qy <= 4'd0;
            force_r <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_r <= state_s;
            tile_qx <= qx_s;
            tile_qy <= qy_s;
            force_r <= q_force_s;
            busy    <= (state_s != ST_WAIT);
        end
    end

    // Working copies of position, velocity and ground contact, updated per phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_r    <= 10'(INIT_X);
            y_r    <= 10'(INIT_Y);
            vel_r  <= 6'sd0;
            og_r   <= 1'b1;
            dx_r   <= 11'sd0;
            cnt_r  <= 3'd0;
            hit0_r <= 1'b0;
        end else begin
            case (state_r)
                ST_WAIT: if (frame_tick) dx_r <= dx_btn_s;
                ST_HQ1, ST_VQ1: hit0_r <= tile_solid | force_r;
                ST_HRES: begin
                    x_r   <= x_new_s;
                    vel_r <= vel_new_s;
                    if (jump_s) og_r <= 1'b0;
                end
                ST_VRES: begin
                    if (v_block_s) begin
                        y_r   <= v_snap_s;
                        vel_r <= 6'sd0;
                        if (vel_r > 6'sd0) og_r <= 1'b1;
                    end else begin
                        y_r  <= 10'(ny_s);
                        og_r <= 1'b0;
                    end
                end
                ST_ANIM: cnt_r <= cnt_s;
                default: hit0_r <= hit0_r;
            endcase
        end
    end

    // Visible sprite state, changed only in ANIM so the consumer sees a coherent set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            img_x     <= 10'(INIT_X);
            img_y     <= 10'(INIT_Y);
            frame_idx <= 3'd0;
            is_moving <= 1'b0;
            face_left <= 1'b0;
            on_ground <= 1'b1;
        end else if (state_r == ST_ANIM) begin
            img_x     <= x_r;
            img_y     <= y_r;
            frame_idx <= frame_s;
            is_moving <= moving_s;
            face_left <= face_s;
            on_ground <= og_r;
        end
    end

endmodule
